// File: rtl/aes_pkg.sv
// Shared AES definitions: state-word geometry, ShiftRows engine states and
// the byte-rotation helper used by the row permutation.
package aes_pkg;

  localparam int ROW_W   = 32;
  localparam int BLOCK_W = 128;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WAIT,
    ST_CAP,
    ST_WR,
    ST_DONE
  } srows_state_t;

  // Rotate a 32-bit row by amt bytes: left when inv=0, right when inv=1.
  // A right rotation by amt is the same as a left rotation by (4-amt) mod 4.
  function automatic logic [ROW_W-1:0] rot_row(input logic [ROW_W-1:0] row,
                                              input logic [1:0]       amt,
                                              input logic             inv);
    logic [2*ROW_W-1:0] dbl;
    logic [1:0]         sh;
    dbl = {row, row};
    sh  = inv ? (2'd0 - amt) : amt;
    return dbl[2*ROW_W-1-8*int'(sh) -: ROW_W];
  endfunction

endpackage

// File: rtl/srows_engine_if.sv
// SRAM port bundle between the ShiftRows engine (master) and the shared
// state-word SRAM (slave).
interface srows_engine_if #(
  parameter int ADDR_W = 16
);
  import aes_pkg::*;

  logic               sramRead;
  logic               sramWrite;
  logic [ADDR_W-1:0]  sramAddr;
  logic [BLOCK_W-1:0] sramWriteValue;
  logic [BLOCK_W-1:0] sramReadValue;

  modport master (
    output sramRead, sramWrite, sramAddr, sramWriteValue,
    input  sramReadValue
  );

  modport slave (
    input  sramRead, sramWrite, sramAddr, sramWriteValue,
    output sramReadValue
  );

endinterface

// File: rtl/srows_perm.sv
// Combinational ShiftRows / InvShiftRows permutation of one 128-bit state
// word. Row r sits at bits [127-32r -: 32] and is rotated by r bytes.
module srows_perm
  import aes_pkg::*;
(
  input  logic [BLOCK_W-1:0] din,
  input  logic               inverse,
  output logic [BLOCK_W-1:0] dout
);

  for (genvar r = 0; r < 4; r++) begin : g_row
    assign dout[BLOCK_W-1-ROW_W*r -: ROW_W] =
      rot_row(din[BLOCK_W-1-ROW_W*r -: ROW_W], 2'(r), inverse);
  end

endmodule

// File: rtl/srows_engine.sv
// Multi-block, bidirectional ShiftRows engine. Walks NUM_BLOCKS state words
// in SRAM: read, wait out the read latency, permute, write back, then pulse
// done. All outputs come straight from flops.
module srows_engine
  import aes_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int BASE_ADDR   = 32,
  parameter int ADDR_STRIDE = 1,
  parameter int DST_OFFSET  = 0,
  parameter int NUM_BLOCKS  = 1,
  parameter int READ_LAT    = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           inverse,
  output logic           busy,
  output logic           done,
  srows_engine_if.master sram
);

  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] STRIDE   = ADDR_W'(ADDR_STRIDE);
  localparam logic [ADDR_W-1:0] OFFSET   = ADDR_W'(DST_OFFSET);
  localparam logic [7:0]        LAST_BLK = 8'(NUM_BLOCKS - 1);
  localparam logic [2:0]        WAIT_INI = 3'((READ_LAT > 1) ? READ_LAT - 2 : 0);

  srows_state_t       state;
  logic [7:0]         blk_cnt;
  logic [ADDR_W-1:0]  rd_addr;
  logic [2:0]         wait_cnt;
  logic               cap_phase;
  logic               inv_q;
  logic [BLOCK_W-1:0] rdata_q;
  logic [BLOCK_W-1:0] wdata_q;
  logic [BLOCK_W-1:0] perm_out;
  logic               rd_q;
  logic               wr_q;
  logic [ADDR_W-1:0]  addr_q;

  srows_perm u_perm (
    .din     (rdata_q),
    .inverse (inv_q),
    .dout    (perm_out)
  );

  assign sram.sramRead       = rd_q;
  assign sram.sramWrite      = wr_q;
  assign sram.sramAddr       = addr_q;
  assign sram.sramWriteValue = wdata_q;

  // Control FSM with registered strobes, address, busy/done and datapath.
  // CAP spends two cycles: the first lands SRAM data in rdata_q exactly
  // READ_LAT cycles after RD, the second registers the permuted word, so the
  // SRAM read data never feeds the rotation muxes in the same cycle.
  // NOTE: every flop here, datapath included, is cleared by reset so the
  // write-data port reads 0 and no stale strobe survives a mid-run reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      blk_cnt   <= '0;
      rd_addr   <= '0;
      wait_cnt  <= '0;
      cap_phase <= 1'b0;
      inv_q     <= 1'b0;
      rdata_q   <= '0;
      wdata_q   <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout; the defaults below are
      // overridden by the case arm, giving one-cycle strobes and pulses.
      rd_q   <= 1'b0;
      wr_q   <= 1'b0;
      addr_q <= '0;
      done   <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            inv_q   <= inverse;
            blk_cnt <= '0;
            rd_addr <= BASE;
            busy    <= 1'b1;
            rd_q    <= 1'b1;
            addr_q  <= BASE;
            state   <= ST_RD;
          end
        end
        ST_RD: begin
          cap_phase <= 1'b0;
          wait_cnt  <= WAIT_INI;
          state     <= (READ_LAT > 1) ? ST_WAIT : ST_CAP;
        end
        ST_WAIT: begin
          if (wait_cnt == '0) state <= ST_CAP;
          else                wait_cnt <= wait_cnt - 3'd1;
        end
        ST_CAP: begin
          if (!cap_phase) begin
            rdata_q   <= sram.sramReadValue;
            cap_phase <= 1'b1;
          end else begin
            wdata_q <= perm_out;
            wr_q    <= 1'b1;
            addr_q  <= rd_addr + OFFSET;
            state   <= ST_WR;
          end
        end
        ST_WR: begin
          if (blk_cnt == LAST_BLK) begin
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            blk_cnt <= blk_cnt + 8'd1;
            rd_addr <= rd_addr + STRIDE;
            rd_q    <= 1'b1;
            addr_q  <= rd_addr + STRIDE;
            state   <= ST_RD;
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_srows_engine.sv
// Directed bench for srows_engine: three configurations, each with its own
// behavioural SRAM, covering forward/inverse runs, multi-block strides and
// offsets, address wrap, start filtering and mid-run reset.
module tb_srows_engine;
  import aes_pkg::*;

  localparam logic [127:0] V_IN    = 128'h00010203_04050607_08090a0b_0c0d0e0f;
  localparam logic [127:0] V_FWD   = 128'h00010203_05060704_0a0b0809_0f0c0d0e;
  localparam logic [127:0] V_INV   = 128'h00010203_07040506_0a0b0809_0d0e0f0c;
  localparam logic [127:0] V_B     = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] V_B_FWD = 128'h00112233_55667744_aabb8899_ffccddee;
  localparam logic [127:0] V_B_INV = 128'h00112233_77445566_aabb8899_ddeeffcc;
  localparam logic [127:0] V_C     = 128'h10203040_50607080_90a0b0c0_d0e0f000;
  localparam logic [127:0] V_C_FWD = 128'h10203040_60708050_b0c090a0_00d0e0f0;
  localparam logic [127:0] V_C_INV = 128'h10203040_80506070_b0c090a0_e0f000d0;
  localparam logic [127:0] GARBAGE = {4{32'hdeadbeef}};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_init = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  logic start0 = 1'b0, inv0 = 1'b0, busy0, done0;
  logic start1 = 1'b0, inv1 = 1'b0, busy1, done1;
  logic start2 = 1'b0, inv2 = 1'b0, busy2, done2;

  srows_engine_if #(.ADDR_W(16)) if0 ();
  srows_engine_if #(.ADDR_W(16)) if1 ();
  srows_engine_if #(.ADDR_W(16)) if2 ();

  srows_engine u0 (.clk(clk), .rst(rst), .start(start0), .inverse(inv0),
                   .busy(busy0), .done(done0), .sram(if0));
  srows_engine #(.ADDR_STRIDE(4), .DST_OFFSET(100), .NUM_BLOCKS(3), .READ_LAT(1))
    u1 (.clk(clk), .rst(rst), .start(start1), .inverse(inv1),
        .busy(busy1), .done(done1), .sram(if1));
  srows_engine #(.BASE_ADDR('hFFFE), .NUM_BLOCKS(3))
    u2 (.clk(clk), .rst(rst), .start(start2), .inverse(inv2),
        .busy(busy2), .done(done2), .sram(if2));

  // SRAM models: read data valid exactly READ_LAT cycles after the read cycle,
  // garbage otherwise, so a mistimed capture shows up in the written data.
  logic [127:0] mem0 [0:65535];
  logic [127:0] mem1 [0:65535];
  logic [127:0] mem2 [0:65535];
  logic [127:0] pipe0 [0:1];
  logic [127:0] pipe1;
  logic [127:0] pipe2 [0:1];

  always @(posedge clk) begin
    if (mem_init) mem0[32] <= V_IN;
    else if (if0.sramWrite) mem0[if0.sramAddr] <= if0.sramWriteValue;
    pipe0[0] <= if0.sramRead ? mem0[if0.sramAddr] : GARBAGE;
    pipe0[1] <= pipe0[0];
  end
  assign if0.sramReadValue = pipe0[1];

  always @(posedge clk) begin
    if (mem_init) begin
      mem1[32] <= V_IN; mem1[36] <= V_B; mem1[40] <= V_C;
    end else if (if1.sramWrite) mem1[if1.sramAddr] <= if1.sramWriteValue;
    pipe1 <= if1.sramRead ? mem1[if1.sramAddr] : GARBAGE;
  end
  assign if1.sramReadValue = pipe1;

  always @(posedge clk) begin
    if (mem_init) begin
      mem2[16'hFFFE] <= V_IN; mem2[16'hFFFF] <= V_B; mem2[16'h0000] <= V_C;
    end else if (if2.sramWrite) mem2[if2.sramAddr] <= if2.sramWriteValue;
    pipe2[0] <= if2.sramRead ? mem2[if2.sramAddr] : GARBAGE;
    pipe2[1] <= pipe2[0];
  end
  assign if2.sramReadValue = pipe2[1];

  // Bus monitors, sampled mid-cycle.
  logic [15:0]  rda0[$], wra0[$], rda1[$], wra1[$], rda2[$], wra2[$];
  logic [127:0] wrd0[$], wrd1[$], wrd2[$];
  int done_n0 = 0, done_c0 = 0, busy_n0 = 0, both0 = 0;
  int done_n1 = 0, done_c1 = 0, both1 = 0;
  int done_n2 = 0, done_c2 = 0, both2 = 0;

  always @(negedge clk) begin
    if (if0.sramRead) rda0.push_back(if0.sramAddr);
    if (if0.sramWrite) begin wra0.push_back(if0.sramAddr); wrd0.push_back(if0.sramWriteValue); end
    if (if0.sramRead && if0.sramWrite) both0 <= both0 + 1;
    if (done0) begin done_n0 <= done_n0 + 1; done_c0 <= cyc; end
    if (busy0) busy_n0 <= busy_n0 + 1;
  end

  always @(negedge clk) begin
    if (if1.sramRead) rda1.push_back(if1.sramAddr);
    if (if1.sramWrite) begin wra1.push_back(if1.sramAddr); wrd1.push_back(if1.sramWriteValue); end
    if (if1.sramRead && if1.sramWrite) both1 <= both1 + 1;
    if (done1) begin done_n1 <= done_n1 + 1; done_c1 <= cyc; end
  end

  always @(negedge clk) begin
    if (if2.sramRead) rda2.push_back(if2.sramAddr);
    if (if2.sramWrite) begin wra2.push_back(if2.sramAddr); wrd2.push_back(if2.sramWriteValue); end
    if (if2.sramRead && if2.sramWrite) both2 <= both2 + 1;
    if (done2) begin done_n2 <= done_n2 + 1; done_c2 <= cyc; end
  end

  // Pulse start on instance k, flip inverse right after acceptance, and
  // return start-to-done latency in cycles (-1 if done never arrives).
  task automatic run(input int k, input logic inv, output int lat);
    int base_n, cur, s;
    @(negedge clk);
    base_n = (k == 0) ? done_n0 : (k == 1) ? done_n1 : done_n2;
    case (k)
      0: begin start0 = 1'b1; inv0 = inv; end
      1: begin start1 = 1'b1; inv1 = inv; end
      default: begin start2 = 1'b1; inv2 = inv; end
    endcase
    s = cyc;
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    inv0 = ~inv0; inv1 = ~inv1; inv2 = ~inv2;
    lat = -1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      cur = (k == 0) ? done_n0 : (k == 1) ? done_n1 : done_n2;
      if (cur != base_n) begin
        lat = ((k == 0) ? done_c0 : (k == 1) ? done_c1 : done_c2) - s;
        break;
      end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_cmp++; if (busy0 !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b expected 0", busy0); end
    n_cmp++; if (done0 !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b expected 0", done0); end
    n_cmp++; if (if0.sramRead !== 1'b0) begin n_bad++; $display("FAIL rst_read: got %b expected 0", if0.sramRead); end
    n_cmp++; if (if0.sramWrite !== 1'b0) begin n_bad++; $display("FAIL rst_write: got %b expected 0", if0.sramWrite); end
    n_cmp++; if (if0.sramAddr !== 16'h0) begin n_bad++; $display("FAIL rst_addr: got %h expected 0", if0.sramAddr); end
    n_cmp++; if (if0.sramWriteValue !== 128'h0) begin n_bad++; $display("FAIL rst_wdata: got %h expected 0", if0.sramWriteValue); end
    rst = 1'b0;
    mem_init = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_forward;
    int lat, r, w, b;
    r = rda0.size(); w = wra0.size(); b = busy_n0;
    run(0, 1'b0, lat);
    @(negedge clk);
    n_cmp++; if (lat !== 6) begin n_bad++; $display("FAIL fwd_latency: got %0d expected 6", lat); end
    n_cmp++; if (rda0.size() - r !== 1 || rda0[r] !== 16'd32) begin n_bad++; $display("FAIL fwd_read_addr: got %h expected 0020", rda0[r]); end
    n_cmp++; if (wra0.size() - w !== 1 || wra0[w] !== 16'd32) begin n_bad++; $display("FAIL fwd_write_addr: got %h expected 0020", wra0[w]); end
    n_cmp++; if (wrd0[w] !== V_FWD) begin n_bad++; $display("FAIL fwd_write_data: got %h expected %h", wrd0[w], V_FWD); end
    n_cmp++; if (busy_n0 - b !== 6) begin n_bad++; $display("FAIL fwd_busy_cycles: got %0d expected 6", busy_n0 - b); end
    n_cmp++; if (if0.sramWriteValue !== V_FWD) begin n_bad++; $display("FAIL fwd_wdata_hold: got %h expected %h", if0.sramWriteValue, V_FWD); end
  endtask

  task automatic test_inverse;
    int lat, w;
    w = wra0.size();
    run(0, 1'b1, lat);
    n_cmp++; if (wrd0[w] !== V_IN) begin n_bad++; $display("FAIL inv_restore: got %h expected %h", wrd0[w], V_IN); end
    run(0, 1'b1, lat);
    n_cmp++; if (lat !== 6) begin n_bad++; $display("FAIL inv_latency: got %0d expected 6", lat); end
    n_cmp++; if (wra0.size() - w !== 2 || wrd0[w+1] !== V_INV) begin n_bad++; $display("FAIL inv_write_data: got %h expected %h", wrd0[w+1], V_INV); end
  endtask

  task automatic test_multi_block;
    int lat, r, w;
    logic [15:0]  exp_rd [3] = '{16'd32, 16'd36, 16'd40};
    logic [15:0]  exp_wa [3] = '{16'd132, 16'd136, 16'd140};
    logic [127:0] exp_wd [3] = '{V_FWD, V_B_FWD, V_C_FWD};
    r = rda1.size(); w = wra1.size();
    run(1, 1'b0, lat);
    n_cmp++; if (lat !== 13) begin n_bad++; $display("FAIL multi_latency: got %0d expected 13", lat); end
    n_cmp++; if (rda1.size() - r !== 3 || wra1.size() - w !== 3) begin n_bad++; $display("FAIL multi_counts: got %0d/%0d expected 3/3", rda1.size() - r, wra1.size() - w); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (rda1[r+i] !== exp_rd[i]) begin n_bad++; $display("FAIL multi_read_addr[%0d]: got %h expected %h", i, rda1[r+i], exp_rd[i]); end
      n_cmp++; if (wra1[w+i] !== exp_wa[i]) begin n_bad++; $display("FAIL multi_write_addr[%0d]: got %h expected %h", i, wra1[w+i], exp_wa[i]); end
      n_cmp++; if (wrd1[w+i] !== exp_wd[i]) begin n_bad++; $display("FAIL multi_write_data[%0d]: got %h expected %h", i, wrd1[w+i], exp_wd[i]); end
    end
  endtask

  task automatic test_wrap;
    int lat, r, w;
    logic [15:0]  exp_a  [3] = '{16'hFFFE, 16'hFFFF, 16'h0000};
    logic [127:0] exp_wd [3] = '{V_INV, V_B_INV, V_C_INV};
    r = rda2.size(); w = wra2.size();
    run(2, 1'b1, lat);
    n_cmp++; if (lat !== 16) begin n_bad++; $display("FAIL wrap_latency: got %0d expected 16", lat); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (rda2[r+i] !== exp_a[i]) begin n_bad++; $display("FAIL wrap_read_addr[%0d]: got %h expected %h", i, rda2[r+i], exp_a[i]); end
      n_cmp++; if (wra2[w+i] !== exp_a[i]) begin n_bad++; $display("FAIL wrap_write_addr[%0d]: got %h expected %h", i, wra2[w+i], exp_a[i]); end
      n_cmp++; if (wrd2[w+i] !== exp_wd[i]) begin n_bad++; $display("FAIL wrap_write_data[%0d]: got %h expected %h", i, wrd2[w+i], exp_wd[i]); end
    end
  endtask

  task automatic test_start_hold;
    int b, r, w;
    @(negedge clk);
    b = done_n0; r = rda0.size(); w = wra0.size();
    start0 = 1'b1;
    repeat (6) @(negedge clk);
    n_cmp++; if (done0 !== 1'b1) begin n_bad++; $display("FAIL hold_done_cycle: got %b expected 1", done0); end
    @(negedge clk);
    start0 = 1'b0;
    repeat (15) @(negedge clk);
    n_cmp++; if (done_n0 - b !== 1) begin n_bad++; $display("FAIL hold_done_pulses: got %0d expected 1", done_n0 - b); end
    n_cmp++; if (rda0.size() - r !== 1) begin n_bad++; $display("FAIL hold_reads: got %0d expected 1", rda0.size() - r); end
    n_cmp++; if (wra0.size() - w !== 1) begin n_bad++; $display("FAIL hold_writes: got %0d expected 1", wra0.size() - w); end
  endtask

  task automatic test_reset_mid_run;
    int lat, r, w;
    @(negedge clk);
    r = rda2.size(); w = wra2.size();
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    // Six more negedges land in the WAIT cycle of the second block.
    repeat (6) @(negedge clk);
    n_cmp++; if (rda2.size() - r !== 2) begin n_bad++; $display("FAIL midrst_reads_before: got %0d expected 2", rda2.size() - r); end
    rst = 1'b1;
    #1;
    n_cmp++; if (busy2 !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %b expected 0", busy2); end
    n_cmp++; if (done2 !== 1'b0) begin n_bad++; $display("FAIL midrst_done: got %b expected 0", done2); end
    n_cmp++; if (if2.sramRead !== 1'b0 || if2.sramWrite !== 1'b0) begin n_bad++; $display("FAIL midrst_strobes: got %b%b expected 00", if2.sramRead, if2.sramWrite); end
    n_cmp++; if (if2.sramAddr !== 16'h0) begin n_bad++; $display("FAIL midrst_addr: got %h expected 0", if2.sramAddr); end
    n_cmp++; if (if2.sramWriteValue !== 128'h0) begin n_bad++; $display("FAIL midrst_wdata: got %h expected 0", if2.sramWriteValue); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    n_cmp++; if (wra2.size() - w !== 1 || wra2[w] !== 16'hFFFE) begin n_bad++; $display("FAIL midrst_writes: got %0d writes, first %h, expected 1 at fffe", wra2.size() - w, wra2[w]); end
    r = rda2.size();
    run(2, 1'b0, lat);
    n_cmp++; if (lat !== 16) begin n_bad++; $display("FAIL midrst_rerun_latency: got %0d expected 16", lat); end
    n_cmp++; if (rda2[r] !== 16'hFFFE) begin n_bad++; $display("FAIL midrst_restart_addr: got %h expected fffe", rda2[r]); end
  endtask

  task automatic test_strobe_exclusive;
    n_cmp++; if (both0 + both1 + both2 !== 0) begin n_bad++; $display("FAIL strobe_overlap: got %0d cycles expected 0", both0 + both1 + both2); end
  endtask

  initial begin
    test_reset;
    test_forward;
    test_inverse;
    test_multi_block;
    test_wrap;
    test_start_hold;
    test_reset_mid_run;
    test_strobe_exclusive;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish before 100000");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/srows_engine.md
# srows_engine

Parametrised AES ShiftRows / InvShiftRows engine that sits beside the cipher round controller and operates in place on 128-bit state words in the shared SRAM. On a start pulse it walks `NUM_BLOCKS` consecutive state words, reading each one, permuting it forward or inverse, and writing the result back. It pulses `done` when the last write has issued. It generalises the single-address, forward-only shift-rows step to multi-block, bidirectional, configurable-latency operation.

## Interface

Parameters:
- `ADDR_W`, 16: SRAM address width.
- `BASE_ADDR`, 32: address of block 0.
- `ADDR_STRIDE`, 1: address increment between blocks.
- `DST_OFFSET`, 0: write address = read address + `DST_OFFSET`, modulo 2^`ADDR_W`. 0 means in place.
- `NUM_BLOCKS`, 1: blocks per run, 1..255.
- `READ_LAT`, 2: cycles from the `sramRead` cycle to valid `sramReadValue`, 1..7.

Ports:
- `clk`, in, 1: clock, rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: begin a run. Sampled only in IDLE.
- `inverse`, in, 1: 0 selects ShiftRows, 1 selects InvShiftRows. Latched with `start`.
- `busy`, out, 1: high from the cycle after `start` is accepted through the DONE state inclusive.
- `done`, out, 1: one-cycle pulse in DONE.
- `sramReadValue`, in, 128: SRAM read data.
- `sramRead`, out, 1: read strobe.
- `sramWrite`, out, 1: write strobe.
- `sramAddr`, out, `ADDR_W`: SRAM address. 0 whenever no strobe is active.
- `sramWriteValue`, out, 128: write data. Holds the last captured result.

## Operation

- State layout is row-major. Row r occupies bits [127-32r -: 32], most significant byte first.
  - Forward: row r is rotated left by r bytes.
  - Inverse: row r is rotated right by r bytes.
  - Row 0 always passes through unchanged.
- State machine states: IDLE, RD, WAIT, CAP, WR, DONE.
  - IDLE → RD when `start`=1. Latch `inverse`, set block counter = 0 and read address = `BASE_ADDR`.
  - RD: `sramRead`=1, `sramAddr`=read address. Go to WAIT.
  - WAIT: stay `READ_LAT`-1 cycles, then go to CAP. If `READ_LAT`=1, WAIT is skipped.
  - CAP: register perm(`sramReadValue`) into the write-data register. Go to WR.
  - WR: `sramWrite`=1, `sramAddr`=read address + `DST_OFFSET`. Then:
    - If counter = `NUM_BLOCKS`-1, go to DONE.
    - Otherwise increment the counter, add `ADDR_STRIDE` to the read address, and go to RD.
  - DONE: `done`=1. Go to IDLE.
- Address arithmetic is `ADDR_W` bits and wraps modulo 2^`ADDR_W` without error.
- `start` while `busy` is ignored and not queued. `start` in the same cycle DONE→IDLE is also ignored.
- `inverse` changes mid-run have no effect.
- `sramRead` and `sramWrite` are never high in the same cycle.

## Timing

- Reset values: state IDLE, `busy`=0, `done`=0, `sramRead`=0, `sramWrite`=0, `sramAddr`=0, `sramWriteValue`=0, counter 0.
- Reset asserted mid-run returns the block to IDLE immediately. No further strobes are issued, and the partially processed block is not written.
- Per-block cycles: 3 + `READ_LAT` (RD, `READ_LAT`-1 WAIT cycles, CAP, WR, with CAP sampling at RD + `READ_LAT`).
- Run latency: `start` cycle to `done` cycle = `NUM_BLOCKS`·(3+`READ_LAT`) + 1.
- All outputs are registered or decoded from state only. No combinational path from `sramReadValue` to any output.

## Structure

- Package `aes_pkg` holds:
  - state enum `srows_state_t`;
  - row-width constant 32 and block-width constant 128;
  - function `rot_row(row, amt, inv)`.
- Sub-module `srows_perm`: purely combinational 128-bit permutation with an `inverse` select. It is reused later by the inverse cipher datapath.
- `srows_engine` contains the FSM, block counter, address register and write-data register.

## Test plan

1. Forward run, `NUM_BLOCKS`=1, `READ_LAT`=2. Memory[32]=00010203_04050607_08090a0b_0c0d0e0f, `start` pulsed.
   - Write to 32 of 00010203_05060704_0a0b0809_0f0c0d0e.
   - `done` 6 cycles after `start`.
2. Inverse run on the same input.
   - Write 00010203_07040506_0a0b0809_0d0e0f0c.
   - A forward run followed by an inverse run restores the original value.
3. `NUM_BLOCKS`=3, `ADDR_STRIDE`=4, `DST_OFFSET`=100, `READ_LAT`=1.
   - Reads from 32, 36, 40; writes to 132, 136, 140.
   - `done` 13 cycles after `start`.
4. `BASE_ADDR`=FFFE, `NUM_BLOCKS`=3, `ADDR_W`=16.
   - Read addresses FFFE, FFFF, 0000 (wrap).
5. `start` held high through a run and pulsed in the DONE cycle.
   - Exactly one run, one `done` pulse.
6. `rst` asserted in the WAIT of block 2 of 3.
   - All outputs read 0 the same cycle, no write to block 2.
   - The next `start` restarts at `BASE_ADDR`.
